// File: rtl/uart_prog_loader.sv
// UART 8N1 program/data loader driving the ROM/RAM upgrade write bus.
// Define UART_LOADER_CSUM_EN to require a per-region XOR checksum byte.
module uart_prog_loader #(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 128_000,
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              rx,
  output logic              upg_wen_o,
  output logic [ADDR_W:0]   upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int N_W          = ADDR_W + 1;
  localparam int unsigned REGION_WORDS = 32'd1 << ADDR_W;

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  rx_state_t         rx_state_reg, rx_state_next;
  logic              rx_meta_reg, rx_sync_reg;
  logic [CNT_W-1:0]  clk_cnt_reg, clk_cnt_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [7:0]        rx_shift_reg, rx_shift_next;
  logic              byte_vld_reg, byte_vld_next;
  logic              frame_err;

  always_ff @(posedge clock) begin
    if (rst) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      clk_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
      byte_vld_reg <= 1'b0;
    end else begin
      rx_meta_reg  <= rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_state_reg <= rx_state_next;
      clk_cnt_reg  <= clk_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      rx_shift_reg <= rx_shift_next;
      byte_vld_reg <= byte_vld_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    clk_cnt_next  = clk_cnt_reg + CNT_W'(1);
    bit_cnt_next  = bit_cnt_reg;
    rx_shift_next = rx_shift_reg;
    byte_vld_next = 1'b0;
    frame_err     = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        clk_cnt_next = '0;
        if (!rx_sync_reg) rx_state_next = RX_START;
      end
      RX_START: begin
        if (clk_cnt_reg == CNT_W'(HALF_BIT - 1)) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_next  = '0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          bit_cnt_next  = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start.
        if (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_next = '0;
          if (rx_sync_reg) begin
            byte_vld_next = 1'b1;
            rx_state_next = RX_IDLE;
          end else begin
            frame_err     = 1'b1;
            rx_state_next = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        clk_cnt_next = '0;
        if (rx_sync_reg) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // ---------------- command parser ----------------
`ifdef UART_LOADER_CSUM_EN
  typedef enum logic [2:0] {P_CMD, P_CNT_LO, P_CNT_HI, P_DATA, P_CSUM, P_DONE} p_state_t;
  logic [7:0] csum_reg, csum_next;
`else
  typedef enum logic [2:0] {P_CMD, P_CNT_LO, P_CNT_HI, P_DATA, P_DONE} p_state_t;
`endif

  p_state_t          p_state_reg, p_state_next;
  logic              region_reg, region_next;
  logic [7:0]        cnt_lo_reg, cnt_lo_next;
  logic [N_W-1:0]    n_words_reg, n_words_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [23:0]       word_reg, word_next;
  logic [1:0]        byte_idx_reg, byte_idx_next;
  logic              wen_reg, wen_next;
  logic [ADDR_W:0]   adr_reg, adr_next;
  logic [31:0]       dat_reg, dat_next;
  logic              done_reg, done_next;
  logic              busy_reg, busy_next;
  logic              err_reg, err_next;
  logic [15:0]       n_raw;
  logic              last_word;

  assign n_raw     = {rx_shift_reg, cnt_lo_reg};
  assign last_word = ({1'b0, addr_reg} == (n_words_reg - N_W'(1)));

  always_ff @(posedge clock) begin
    if (rst) begin
      p_state_reg  <= P_CMD;
      region_reg   <= 1'b0;
      cnt_lo_reg   <= '0;
      n_words_reg  <= '0;
      addr_reg     <= '0;
      word_reg     <= '0;
      byte_idx_reg <= '0;
      wen_reg      <= 1'b0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
      csum_reg     <= '0;
`endif
    end else begin
      p_state_reg  <= p_state_next;
      region_reg   <= region_next;
      cnt_lo_reg   <= cnt_lo_next;
      n_words_reg  <= n_words_next;
      addr_reg     <= addr_next;
      word_reg     <= word_next;
      byte_idx_reg <= byte_idx_next;
      wen_reg      <= wen_next;
      adr_reg      <= adr_next;
      dat_reg      <= dat_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
`ifdef UART_LOADER_CSUM_EN
      csum_reg     <= csum_next;
`endif
    end
  end

  always_comb begin
    p_state_next  = p_state_reg;
    region_next   = region_reg;
    cnt_lo_next   = cnt_lo_reg;
    n_words_next  = n_words_reg;
    addr_next     = addr_reg;
    word_next     = word_reg;
    byte_idx_next = byte_idx_reg;
    wen_next      = 1'b0;
    adr_next      = adr_reg;
    dat_next      = dat_reg;
    done_next     = done_reg;
    busy_next     = busy_reg;
    err_next      = err_reg | frame_err;
`ifdef UART_LOADER_CSUM_EN
    csum_next     = csum_reg;
`endif
    if (byte_vld_reg) begin
      case (p_state_reg)
        P_CMD: begin
          case (rx_shift_reg)
            8'h52:   begin region_next = 1'b0; p_state_next = P_CNT_LO; end
            8'h44:   begin region_next = 1'b1; p_state_next = P_CNT_LO; end
            8'h45:   begin done_next = 1'b1;   p_state_next = P_DONE;   end
            default: err_next = 1'b1;
          endcase
        end
        P_CNT_LO: begin
          cnt_lo_next  = rx_shift_reg;
          p_state_next = P_CNT_HI;
        end
        P_CNT_HI: begin
          // Zero or oversize counts fill the whole region.
          if (n_raw == 16'd0 || 32'(n_raw) > REGION_WORDS)
            n_words_next = N_W'(REGION_WORDS);
          else
            n_words_next = N_W'(n_raw);
          addr_next     = '0;
          byte_idx_next = '0;
          busy_next     = 1'b1;
`ifdef UART_LOADER_CSUM_EN
          csum_next     = '0;
`endif
          p_state_next  = P_DATA;
        end
        P_DATA: begin
          word_next     = {rx_shift_reg, word_reg[23:8]};
          byte_idx_next = byte_idx_reg + 2'd1;
`ifdef UART_LOADER_CSUM_EN
          csum_next     = csum_reg ^ rx_shift_reg;
`endif
          if (byte_idx_reg == 2'd3) begin
            wen_next = 1'b1;
            adr_next = {region_reg, addr_reg};
            dat_next = {rx_shift_reg, word_reg};
            if (last_word) begin
`ifdef UART_LOADER_CSUM_EN
              p_state_next = P_CSUM;
`else
              busy_next    = 1'b0;
              p_state_next = P_CMD;
`endif
            end else begin
              addr_next = addr_reg + ADDR_W'(1);
            end
          end
        end
`ifdef UART_LOADER_CSUM_EN
        P_CSUM: begin
          if (rx_shift_reg != csum_reg) err_next = 1'b1;
          busy_next    = 1'b0;
          p_state_next = P_CMD;
        end
`endif
        P_DONE: p_state_next = P_DONE;
        default: p_state_next = P_CMD;
      endcase
    end
  end

  assign upg_wen_o  = wen_reg;
  assign upg_adr_o  = adr_reg;
  assign upg_dat_o  = dat_reg;
  assign upg_done_o = done_reg;
  assign busy_o     = busy_reg;
  assign err_o      = err_reg;

endmodule
